// File: rtl/ram_bytes_sync.sv
// Byte-addressable data RAM with per-lane write enables, registered reads,
// unaligned wrap-around accesses and a hardware clear engine that zeroes memory.
module ram_bytes_sync #(
  parameter int addrSize  = 9,
  parameter int wordBytes = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     output_en,
  input  logic [addrSize-1:0]      addr,
  input  logic [8*wordBytes-1:0]   data_in,
  input  logic [wordBytes-1:0]     byte_en,
  input  logic                     write_rq,
  input  logic                     read_rq,
  input  logic                     clear_rq,
  output logic                     ready,
  output logic [8*wordBytes-1:0]   data_out,
  output logic                     data_valid
);

  localparam int DEPTH = 2 ** addrSize;
  localparam int DW    = 8 * wordBytes;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state;
  logic [addrSize-1:0] ptr;
  logic [DW-1:0]       data_q;
  logic [7:0]          mem [DEPTH];

  logic [addrSize-1:0] lane_addr [wordBytes];
  logic [addrSize-1:0] clr_addr  [wordBytes];
  logic                clear_we;
  logic                wr_go;
  logic                rd_go;

  // Lane addresses wrap naturally by truncating to addrSize bits.
  always_comb begin
    for (int i = 0; i < wordBytes; i++) begin
      lane_addr[i] = addr + addrSize'(i);
      clr_addr[i]  = ptr + addrSize'(i);
    end
  end

  assign ready    = (state == IDLE);
  assign wr_go    = ready && write_rq;
  assign rd_go    = ready && read_rq;
  // Reset holds the engine at pointer 0 but must not itself scrub memory.
  assign clear_we = (state == CLEAR) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == addrSize'(DEPTH - wordBytes)) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + addrSize'(wordBytes);
          end
        end
        IDLE: begin
          if (clear_rq) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: the storage array has no reset branch; clearing is done by the
  // engine one word per cycle so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      for (int i = 0; i < wordBytes; i++) mem[clr_addr[i]] <= 8'h00;
    end else if (wr_go) begin
      for (int i = 0; i < wordBytes; i++)
        if (byte_en[i]) mem[lane_addr[i]] <= data_in[8*i +: 8];
    end
  end

  // NOTE: non-blocking updates make a same-edge read see the pre-write bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_go;
      if (rd_go) begin
        for (int i = 0; i < wordBytes; i++) data_q[8*i +: 8] <= mem[lane_addr[i]];
      end
    end
  end

  assign data_out = output_en ? data_q : '0;

endmodule

// File: tb/tb_ram_bytes_sync.sv
// Directed self-checking bench for ram_bytes_sync (addrSize=9, wordBytes=2).
module tb_ram_bytes_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        output_en;
  logic [8:0]  addr;
  logic [15:0] data_in;
  logic [1:0]  byte_en;
  logic        write_rq;
  logic        read_rq;
  logic        clear_rq;
  logic        ready;
  logic [15:0] data_out;
  logic        data_valid;

  int checks   = 0;
  int failures = 0;
  int n;

  ram_bytes_sync #(.addrSize(9), .wordBytes(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .output_en  (output_en),
    .addr       (addr),
    .data_in    (data_in),
    .byte_en    (byte_en),
    .write_rq   (write_rq),
    .read_rq    (read_rq),
    .clear_rq   (clear_rq),
    .ready      (ready),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises, bounded so a stuck clear still ends.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!ready && cnt < 1000);
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic [1:0] be);
    addr = a; data_in = d; byte_en = be; write_rq = 1'b1;
    tick();
    write_rq = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [8:0] a, input logic [15:0] exp);
    addr = a; read_rq = 1'b1;
    tick();
    read_rq = 1'b0;
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    check(tag, 32'(data_out), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; output_en = 1'b1; addr = '0; data_in = '0; byte_en = '0;
    write_rq = 1'b0; read_rq = 1'b0; clear_rq = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    reset = 1'b0;

    // 1: power-on clear length and zeroed contents
    wait_ready(n);
    check("clear_len", 32'(n), 32'd256);
    rd("rd_000", 9'h000, 16'h0000);
    rd("rd_0fe", 9'h0FE, 16'h0000);
    rd("rd_1fe", 9'h1FE, 16'h0000);

    // 2: full and partial writes
    wr(9'h010, 16'hBEEF, 2'b11);
    rd("rd_010", 9'h010, 16'hBEEF);
    tick();
    check("valid_pulse", 32'(data_valid), 32'd0);
    check("dout_hold", 32'(data_out), 32'hBEEF);
    wr(9'h010, 16'h1234, 2'b01);
    rd("rd_010_be", 9'h010, 16'hBE34);

    // 3: unaligned write wrapping over the top of memory
    wr(9'h1FF, 16'hA55A, 2'b11);
    rd("rd_wrap0", 9'h000, 16'h00A5);
    rd("rd_wrap1ff", 9'h1FF, 16'hA55A);
    rd("rd_1fe_b", 9'h1FE, 16'h5A00);

    // 4: same-cycle read and write return pre-write data
    wr(9'h020, 16'h1111, 2'b11);
    addr = 9'h020; data_in = 16'h2222; byte_en = 2'b11; write_rq = 1'b1; read_rq = 1'b1;
    tick();
    write_rq = 1'b0; read_rq = 1'b0;
    check("rbw_valid", 32'(data_valid), 32'd1);
    check("rbw_old", 32'(data_out), 32'h1111);
    rd("rbw_new", 9'h020, 16'h2222);

    // 6: clear request in IDLE, with a read in the same cycle still served
    wr(9'h010, 16'hBEEF, 2'b11);
    addr = 9'h010; read_rq = 1'b1; clear_rq = 1'b1;
    tick();
    clear_rq = 1'b0;
    check("clr_rd_valid", 32'(data_valid), 32'd1);
    check("clr_rd_data", 32'(data_out), 32'hBEEF);
    check("clr_ready", 32'(ready), 32'd0);
    addr = 9'h020;
    tick();
    read_rq = 1'b0;
    check("drop_valid", 32'(data_valid), 32'd0);
    check("drop_hold", 32'(data_out), 32'hBEEF);
    wait_ready(n);
    check("clr_len", 32'(n + 1), 32'd256);
    output_en = 1'b0;
    #1;
    check("oe_gate", 32'(data_out), 32'd0);
    output_en = 1'b1;
    #1;
    check("oe_retain", 32'(data_out), 32'hBEEF);
    rd("clr_010", 9'h010, 16'h0000);
    rd("clr_020", 9'h020, 16'h0000);

    // 5: async reset in the middle of a clear at pointer 0x080
    wr(9'h030, 16'hCAFE, 2'b11);
    addr = 9'h030; read_rq = 1'b1; clear_rq = 1'b1;
    tick();
    read_rq = 1'b0; clear_rq = 1'b0;
    check("pre_rst_dout", 32'(data_out), 32'hCAFE);
    for (int i = 0; i < 64; i++) tick();
    check("mid_ptr", 32'(dut.ptr), 32'h080);
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_valid", 32'(data_valid), 32'd0);
    check("arst_dout", 32'(data_out), 32'd0);
    tick(); tick();
    reset = 1'b0;
    wait_ready(n);
    check("reclear_len", 32'(n), 32'd256);
    rd("rd_030", 9'h030, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bytes_sync.md
Name: ram_bytes_sync

Overview:
- Parametrised byte-addressable data RAM; next generation of the 16-bit microcontroller RAM.
- Generalised word width, per-byte write enables, registered reads with a valid strobe, and unaligned accesses with wrap-around.
- Adds a hardware clear engine that zeroes memory after reset or on request, with a ready handshake.
- Sits between the CPU bus interface and data storage.

Parameters:
addrSize, 9, byte address width; memory holds 2**addrSize bytes.
wordBytes, 2, bytes per word (1, 2, 4 or 8); data width is 8*wordBytes; must divide 2**addrSize.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
output_en  in  1  gates data_out; when 0, data_out reads 0 (combinational gate only).
addr  in  addrSize  byte address of lane 0 of the access.
data_in  in  8*wordBytes  write data; lane i is data_in[8i+7:8i].
byte_en  in  wordBytes  per-lane write enable.
write_rq  in  1  write request; sampled only when ready=1.
read_rq  in  1  read request; sampled only when ready=1.
clear_rq  in  1  synchronous request to re-zero the whole memory.
ready  out  1  1 when requests are accepted.
data_out  out  8*wordBytes  registered read data, gated by output_en.
data_valid  out  1  one-cycle pulse: data_out register updated this cycle.

Behaviour:
- Reset (async, any time, including mid-clear or mid-read):
  - state=CLEAR, clear pointer=0, ready=0, data_valid=0, data_out register=0.
  - Memory contents are not touched by reset itself.
- States:
  - CLEAR: each cycle writes 0 to wordBytes bytes at the pointer, then pointer += wordBytes. On the cycle the last word is written (pointer = 2**addrSize - wordBytes), go to IDLE; ready=1 from the next cycle.
  - Clear duration: exactly 2**addrSize/wordBytes cycles after reset deasserts.
  - IDLE: ready=1; requests processed.
  - clear_rq=1 in IDLE: go to CLEAR, pointer=0, ready=0 next cycle. Any read or write in that same cycle is still performed.
  - clear_rq is ignored while in CLEAR.
- Requests issued while ready=0 are dropped silently: no write, no data_valid.
- Byte mapping:
  - Lane i maps to byte (addr+i) mod 2**addrSize, little-endian.
  - Unaligned addresses are legal and complete in one cycle.
  - Accesses crossing the top of memory wrap to byte 0.
- Write: with write_rq=1 and ready=1, each lane with byte_en[i]=1 is written at that edge; lanes with byte_en[i]=0 are unchanged.
- Read:
  - With read_rq=1 and ready=1, the data_out register loads the addressed bytes at that edge and data_valid=1 for the following cycle.
  - Read latency is 1 cycle.
  - The register holds its value until the next accepted read or reset.
- Simultaneous read and write, same cycle, overlapping bytes: read returns the pre-write contents (read-before-write). The write still takes effect.
- Back-to-back reads every cycle are supported; data_valid stays high continuously.
- output_en affects only the data_out port value. It does not affect data_valid or the internal register.

Test Plan:
1. addrSize=9, wordBytes=2: pulse reset, deassert -> ready=0 for exactly 256 cycles, then 1. Reads at 0x000, 0x0FE and 0x1FE return 0x0000.
2. Write 0xBEEF at 0x010 with byte_en=2'b11, then read 0x010 -> data_out=0xBEEF one cycle later, data_valid pulsed once. Write 0x1234 at 0x010 with byte_en=2'b01 -> read returns 0xBE34.
3. Unaligned and wrap: write 0xA55A at 0x1FF -> byte 0x1FF=0x5A, byte 0x000=0xA5. Read 0x000 -> 0x??A5, with upper byte = byte 0x001 (0x00 after clear).
4. Same-cycle read+write at 0x020: old value 0x1111, write 0x2222 -> data_out=0x1111. The next read returns 0x2222.
5. Asynchronous reset asserted mid-clear at pointer 0x080 -> ready=0, data_valid=0 and data_out=0 immediately. After release the clear restarts from 0 and takes the full 256 cycles.
6. clear_rq in IDLE after writing 0xBEEF at 0x010 -> ready drops for 256 cycles and 0x010 reads 0x0000. A request issued during the clear is dropped (no data_valid). With output_en=0, data_out=0 while the internal value is retained: raising output_en shows it.
